ball_renderer: RTL and testbench

// - Consumer of the trajectory generator's per-frame ball positions; draws up to 7 balls as filled discs.
// - Once per frame, on nf_in, takes a snapshot of traj_x/traj_y. Tests every streamed pixel (hcount/vcount) against the snapshot.
// - Outputs hit flag, ball index and RGB444 colour to the video mixer after a fixed 3-cycle latency.

---
 rtl/juggle_pkg.sv | 50 +++++
 rtl/ball_hit_test.sv | 90 +++++++++
 rtl/ball_renderer.sv | 186 ++++++++++++++++++
 tb/tb_ball_renderer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/juggle_pkg.sv
// ---------------------------------------------------------------------------
// juggle_pkg
// Shared definitions for the juggling video pipeline.
//   NUM_SLOTS     number of ball slots driven by the trajectory generator
//   X_W / Y_W     pixel coordinate widths (horizontal / vertical)
//   BALL_PALETTE  RGB444 colour per ball slot, index = ball id
//   render_state_t  snapshot capture states used by ball_renderer
//   abs_diff      magnitude of a 12-bit signed coordinate difference
//   active_mask   thermometer mask of the slots below a ball count
// ---------------------------------------------------------------------------
package juggle_pkg;

  localparam int NUM_SLOTS = 7;
  localparam int X_W       = 11;
  localparam int Y_W       = 10;
  localparam int C_W       = 12;

  // Leftmost entry is slot 6, rightmost is slot 0.
  localparam logic [NUM_SLOTS-1:0][C_W-1:0] BALL_PALETTE = {
    12'hFFF,  // slot 6: white
    12'hF0F,  // slot 5: magenta
    12'h0FF,  // slot 4: cyan
    12'hFF0,  // slot 3: yellow
    12'h00F,  // slot 2: blue
    12'h0F0,  // slot 1: green
    12'hF00   // slot 0: red
  };

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    CAPTURE    = 2'd1,
    HOLD       = 2'd2
  } render_state_t;

  // Differences come from zero-extended 11-bit operands, so -2048 never
  // occurs and the magnitude always fits in 11 bits.
  function automatic logic [10:0] abs_diff(input logic signed [11:0] v);
    return v[11] ? (~v[10:0] + 11'd1) : v[10:0];
  endfunction

  // Bit i set when slot i is below the ball count n.
  function automatic logic [NUM_SLOTS-1:0] active_mask(input logic [2:0] n);
    logic [NUM_SLOTS-1:0] m;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      m[i] = (3'(i) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/ball_hit_test.sv
// ---------------------------------------------------------------------------
// ball_hit_test
// Distance test of the streamed pixel against one ball centre, two stages.
//   S1: |dx|, |dy| (low bits only) and the bounding-box "near" flag.
//   S2: dx^2 + dy^2 for near pixels, forced to 0 with near cleared otherwise.
// Ports
//   clk_in, rst_in   clock, asynchronous active-high reset
//   hcount_in        current pixel x
//   vcount_in        current pixel y
//   x_in, y_in       ball centre (from the frame snapshot)
//   near_out         S2: pixel inside the RADIUS bounding box
//   sum_out          S2: squared distance, valid when near_out
// ---------------------------------------------------------------------------
module ball_hit_test
  import juggle_pkg::*;
#(
  parameter int RADIUS = 8
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [X_W-1:0] hcount_in,
  input  logic [Y_W-1:0] vcount_in,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  output logic           near_out,
  output logic [8:0]     sum_out
);

  localparam logic [10:0] R_LIM = 11'(RADIUS);

  logic signed [11:0] w_dx;
  logic signed [11:0] w_dy;
  logic [10:0]        w_adx;
  logic [10:0]        w_ady;
  logic               w_near;

  // Near pixels have |d| <= RADIUS <= 15, so four bits carry the whole value.
  logic [3:0]         r_adx;
  logic [3:0]         r_ady;
  logic               r_near_s1;

  logic [8:0]         w_opx;
  logic [8:0]         w_opy;
  logic [8:0]         w_sum;

  logic               r_near_s2;
  logic [8:0]         r_sum;

  // Zero-extend before subtracting so coordinates never wrap around the screen.
  assign w_dx   = $signed({1'b0, hcount_in}) - $signed({1'b0, x_in});
  assign w_dy   = $signed({2'b00, vcount_in}) - $signed({2'b00, y_in});
  assign w_adx  = abs_diff(w_dx);
  assign w_ady  = abs_diff(w_dy);
  assign w_near = (w_adx <= R_LIM) && (w_ady <= R_LIM);

  // S1 register: clipped magnitudes and bounding-box flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_adx     <= 4'd0;
      r_ady     <= 4'd0;
      r_near_s1 <= 1'b0;
    end else begin
      r_adx     <= w_adx[3:0];
      r_ady     <= w_ady[3:0];
      r_near_s1 <= w_near;
    end
  end

  assign w_opx = {5'd0, r_adx};
  assign w_opy = {5'd0, r_ady};
  assign w_sum = (w_opx * w_opx) + (w_opy * w_opy);

  // S2 register: squared distance only for pixels inside the box.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_near_s2 <= 1'b0;
      r_sum     <= 9'd0;
    end else if (r_near_s1) begin
      r_near_s2 <= 1'b1;
      r_sum     <= w_sum;
    end else begin
      r_near_s2 <= 1'b0;
      r_sum     <= 9'd0;
    end
  end

  assign near_out = r_near_s2;
  assign sum_out  = r_sum;

endmodule

// File: rtl/ball_renderer.sv
// ---------------------------------------------------------------------------
// ball_renderer
// Draws up to NUM_SLOTS balls as filled discs over the streamed video raster.
// Ball positions are snapshotted once per frame (one cycle after nf_in) so a
// frame never tears; every pixel is tested against the snapshot with a fixed
// three-cycle latency and no stall.
// Ports
//   clk_in, rst_in     clock, asynchronous active-high reset
//   nf_in              new-frame strobe (start of vertical blank)
//   traj_x_in/_y_in    ball positions from the trajectory generator
//   traj_valid_in      trajectory outputs meaningful
//   num_balls_in       active ball count 0..7
//   hcount_in/vcount_in/data_valid_in   pixel stream in
//   hit_out, ball_id_out, pixel_out, data_valid_out   pixel stream out
// ---------------------------------------------------------------------------
module ball_renderer
  import juggle_pkg::*;
#(
  parameter int                              RADIUS  = 8,
  parameter logic [NUM_SLOTS-1:0][C_W-1:0]   PALETTE = BALL_PALETTE
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          nf_in,
  input  logic [NUM_SLOTS-1:0][X_W-1:0] traj_x_in,
  input  logic [NUM_SLOTS-1:0][Y_W-1:0] traj_y_in,
  input  logic                          traj_valid_in,
  input  logic [2:0]                    num_balls_in,
  input  logic [X_W-1:0]                hcount_in,
  input  logic [Y_W-1:0]                vcount_in,
  input  logic                          data_valid_in,
  output logic                          hit_out,
  output logic [2:0]                    ball_id_out,
  output logic [C_W-1:0]                pixel_out,
  output logic                          data_valid_out
);

  localparam logic [8:0] R_SQ = 9'(RADIUS * RADIUS);

  render_state_t                 r_state;
  logic [NUM_SLOTS-1:0][X_W-1:0] r_snap_x;
  logic [NUM_SLOTS-1:0][Y_W-1:0] r_snap_y;
  logic [2:0]                    r_snap_num;

  logic [NUM_SLOTS-1:0]          r_act_s1;
  logic [NUM_SLOTS-1:0]          r_act_s2;
  logic                          r_dv_s1;
  logic                          r_dv_s2;

  logic [NUM_SLOTS-1:0]          w_near;
  logic [NUM_SLOTS-1:0][8:0]     w_sum;
  logic [NUM_SLOTS-1:0]          w_in;
  logic                          w_hit;
  logic [2:0]                    w_id;
  logic [C_W-1:0]                w_pix;

  // Capture FSM: positions latch during the single CAPTURE cycle only.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= WAIT_FRAME;
      r_snap_x   <= '0;
      r_snap_y   <= '0;
      r_snap_num <= 3'd0;
    end else begin
      case (r_state)
        WAIT_FRAME: begin
          if (nf_in) begin
            r_state <= CAPTURE;
          end else begin
            r_state <= WAIT_FRAME;
          end
        end
        CAPTURE: begin
          // The generator's registered outputs are current for this frame now.
          if (traj_valid_in) begin
            r_snap_x   <= traj_x_in;
            r_snap_y   <= traj_y_in;
            r_snap_num <= num_balls_in;
          end else begin
            r_snap_num <= 3'd0;
          end
          r_state <= HOLD;
        end
        HOLD: begin
          if (nf_in) begin
            r_state <= CAPTURE;
          end else begin
            r_state <= HOLD;
          end
        end
        default: begin
          r_state <= WAIT_FRAME;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_ball
    ball_hit_test #(
      .RADIUS (RADIUS)
    ) u_hit_test (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .hcount_in (hcount_in),
      .vcount_in (vcount_in),
      .x_in      (r_snap_x[g]),
      .y_in      (r_snap_y[g]),
      .near_out  (w_near[g]),
      .sum_out   (w_sum[g])
    );
  end

  // Active-slot mask and valid travel alongside the pixel, so pixels already
  // in flight keep the ball count that was current when they entered S1.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_act_s1 <= '0;
      r_act_s2 <= '0;
      r_dv_s1  <= 1'b0;
      r_dv_s2  <= 1'b0;
    end else begin
      r_act_s1 <= active_mask(r_snap_num);
      r_act_s2 <= r_act_s1;
      r_dv_s1  <= data_valid_in;
      r_dv_s2  <= r_dv_s1;
    end
  end

  // S3 disc test per slot.
  always_comb begin
    w_in = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_in[i] = w_near[i] && (w_sum[i] <= R_SQ) && r_act_s2[i];
    end
  end

  // Priority encoder: scanning downward leaves the lowest hit index in place.
  always_comb begin
    w_hit = 1'b0;
    w_id  = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_in[i]) begin
        w_hit = 1'b1;
        w_id  = 3'(i);
      end else begin
        w_hit = w_hit;
        w_id  = w_id;
      end
    end
  end

  // Palette lookup; black whenever nothing is hit.
  always_comb begin
    w_pix = 12'h000;
    if (w_hit) begin
      case (w_id)
        3'd0:    w_pix = PALETTE[0];
        3'd1:    w_pix = PALETTE[1];
        3'd2:    w_pix = PALETTE[2];
        3'd3:    w_pix = PALETTE[3];
        3'd4:    w_pix = PALETTE[4];
        3'd5:    w_pix = PALETTE[5];
        3'd6:    w_pix = PALETTE[6];
        default: w_pix = 12'h000;
      endcase
    end else begin
      w_pix = 12'h000;
    end
  end

  // S3 output register toward the video mixer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_out        <= 1'b0;
      ball_id_out    <= 3'd0;
      pixel_out      <= 12'h000;
      data_valid_out <= 1'b0;
    end else begin
      hit_out        <= w_hit;
      ball_id_out    <= w_id;
      pixel_out      <= w_pix;
      data_valid_out <= r_dv_s2;
    end
  end

endmodule

// File: tb/tb_ball_renderer.sv
// ---------------------------------------------------------------------------
// tb_ball_renderer
// Scoreboard bench: each driven pixel pushes its expected output computed
// from a bench-side frame snapshot model; outputs are popped and compared
// three cycles later.
// ---------------------------------------------------------------------------
module tb_ball_renderer;

  localparam int RADIUS = 8;
  localparam logic [11:0] PAL [0:6] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                                        12'h0FF, 12'hF0F, 12'hFFF};

  typedef struct {
    logic [31:0] hit;
    logic [31:0] id;
    logic [31:0] pix;
    logic [31:0] dv;
  } exp_t;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             nf_in;
  logic [6:0][10:0] traj_x_in;
  logic [6:0][9:0]  traj_y_in;
  logic             traj_valid_in;
  logic [2:0]       num_balls_in;
  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic             data_valid_in;
  logic             hit_out;
  logic [2:0]       ball_id_out;
  logic [11:0]      pixel_out;
  logic             data_valid_out;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Bench-side frame model: 0 wait, 1 capture, 2 hold.
  int m_state;
  int m_num;
  int m_x [7];
  int m_y [7];

  ball_renderer #(.RADIUS(RADIUS)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .nf_in          (nf_in),
    .traj_x_in      (traj_x_in),
    .traj_y_in      (traj_y_in),
    .traj_valid_in  (traj_valid_in),
    .num_balls_in   (num_balls_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .data_valid_in  (data_valid_in),
    .hit_out        (hit_out),
    .ball_id_out    (ball_id_out),
    .pixel_out      (pixel_out),
    .data_valid_out (data_valid_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t model_px(input int hc, input int vc, input bit dv);
    exp_t e;
    e.hit = 32'd0;
    e.id  = 32'd0;
    e.pix = 32'd0;
    e.dv  = 32'(dv);
    for (int i = 0; i < 7; i++) begin
      int dx;
      int dy;
      dx = hc - m_x[i];
      dy = vc - m_y[i];
      if (i < m_num && e.hit == 32'd0 && (dx * dx + dy * dy) <= RADIUS * RADIUS) begin
        e.hit = 32'd1;
        e.id  = 32'(i);
        e.pix = 32'(PAL[i]);
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_num   = 0;
    for (int i = 0; i < 7; i++) begin
      m_x[i] = 0;
      m_y[i] = 0;
    end
  endtask

  // One clock: compare the pixel driven three cycles ago, advance the frame
  // model over the edge just taken, then drive and score the next pixel.
  task automatic step(input int hc, input int vc, input bit dv, input bit nf);
    exp_t e;
    @(posedge clk_in);
    #1;
    if (sb.size() >= 3) begin
      e = sb.pop_front();
      check_val("hit_out",        32'(hit_out),        e.hit);
      check_val("ball_id_out",    32'(ball_id_out),    e.id);
      check_val("pixel_out",      32'(pixel_out),      e.pix);
      check_val("data_valid_out", 32'(data_valid_out), e.dv);
    end
    case (m_state)
      0: if (nf_in) m_state = 1;
      1: begin
        if (traj_valid_in) begin
          for (int i = 0; i < 7; i++) begin
            m_x[i] = int'(traj_x_in[i]);
            m_y[i] = int'(traj_y_in[i]);
          end
          m_num = int'(num_balls_in);
        end else begin
          m_num = 0;
        end
        m_state = 2;
      end
      2: if (nf_in) m_state = 1;
      default: m_state = 0;
    endcase
    hcount_in     = 11'(hc);
    vcount_in     = 10'(vc);
    data_valid_in = dv;
    nf_in         = nf;
    sb.push_back(model_px(hc, vc, dv));
  endtask

  task automatic px(input int hc, input int vc);
    step(hc, vc, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1'b0, 1'b0);
  endtask

  task automatic frame();
    step(0, 0, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic set_ball(input int i, input int x, input int y);
    traj_x_in[i] = 11'(x);
    traj_y_in[i] = 10'(y);
  endtask

  initial begin
    rst_in        = 1'b1;
    nf_in         = 1'b0;
    traj_x_in     = '0;
    traj_y_in     = '0;
    traj_valid_in = 1'b1;
    num_balls_in  = 3'd0;
    hcount_in     = 11'd0;
    vcount_in     = 10'd0;
    data_valid_in = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk_in);
    #1;
    check_val("rst_hit",   32'(hit_out),        32'd0);
    check_val("rst_id",    32'(ball_id_out),    32'd0);
    check_val("rst_pixel", 32'(pixel_out),      32'd0);
    check_val("rst_dv",    32'(data_valid_out), 32'd0);
    rst_in = 1'b0;

    // No frame captured yet: nothing drawn even where balls are offered.
    set_ball(0, 100, 200);
    num_balls_in = 3'd7;
    for (int k = 0; k < 16; k++) step(92 + k, 200, (k % 3) != 0, 1'b0);
    px(100, 200);

    // Single ball at (100,200); ball 1 offered but outside the count.
    num_balls_in = 3'd1;
    set_ball(1, 120, 200);
    frame();
    px(100, 200); px(108, 200); px(105, 205);
    px(109, 200); px(106, 206); px(120, 200); px(92, 200); px(100, 192);
    for (int k = 0; k < 20; k++) px(90 + k, 196);

    // Overlap: lowest index wins, then the next index once ball 1 leaves.
    set_ball(0, 700, 400);
    set_ball(1, 300, 150);
    set_ball(2, 300, 150);
    num_balls_in = 3'd3;
    frame();
    px(300, 150); px(305, 153);
    set_ball(1, 600, 400);
    frame();
    px(300, 150); px(600, 400);

    // Ball 3 beyond the count, then an invalid capture blanks the frame.
    set_ball(3, 50, 50);
    num_balls_in = 3'd2;
    frame();
    px(50, 50); px(300, 150);
    traj_valid_in = 1'b0;
    frame();
    px(300, 150); px(600, 400); px(50, 50);
    traj_valid_in = 1'b1;

    // Mid-frame input change must wait for the next capture.
    set_ball(0, 100, 200);
    num_balls_in = 3'd1;
    frame();
    px(100, 200);
    set_ball(0, 400, 200);
    px(100, 200); px(400, 200);
    step(0, 0, 1'b0, 1'b1);   // nf arrives mid-stream
    step(0, 0, 1'b0, 1'b1);   // ignored: FSM is in capture
    px(100, 200); px(400, 200); px(100, 200);

    // Screen edges: no wrap-around either way.
    set_ball(0, 3, 100);
    frame();
    px(0, 100); px(0, 108);
    set_ball(0, 2040, 100);
    frame();
    px(0, 100); px(2047, 100); px(2040, 108);

    // Reset mid-stream with hits in flight.
    set_ball(0, 100, 200);
    frame();
    px(100, 200); px(101, 200); px(102, 200); px(103, 200);
    #1;
    rst_in = 1'b1;
    #1;
    check_val("async_rst_hit",   32'(hit_out),        32'd0);
    check_val("async_rst_id",    32'(ball_id_out),    32'd0);
    check_val("async_rst_pixel", 32'(pixel_out),      32'd0);
    check_val("async_rst_dv",    32'(data_valid_out), 32'd0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    sb.delete();
    model_reset();
    for (int k = 0; k < 6; k++) px(100 + k, 200);
    frame();
    px(100, 200); px(104, 203); px(110, 200);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
